// File: rtl/conv_sequencer.sv
// Address and MAC-strobe sequencer for the 2D convolution datapath.
// Walks every valid output position, issues K*K taps per output, then hands each result off on valid/ready.
module conv_sequencer #(
   parameter int R    = 9,
   parameter int C    = 8,
   parameter int MAXK = 4,
   localparam int K_BITS      = $clog2(MAXK + 1),
   localparam int X_ADDR_BITS = $clog2(R * C),
   localparam int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inputs_loaded,
   input  logic [K_BITS-1:0]      K,
   output logic [X_ADDR_BITS-1:0] X_read_addr,
   output logic [W_ADDR_BITS-1:0] W_read_addr,
   output logic                   mac_en,
   output logic                   mac_init,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   compute_finished
);

   localparam int I_BITS = $clog2(R + 1);
   localparam int J_BITS = $clog2(C + 1);
   localparam int XW     = X_ADDR_BITS + 1;
   localparam int WW     = W_ADDR_BITS + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_OUTPUT,
      S_DONE
   } state_e;

   state_e                 state_q, state_d;
   logic [K_BITS-1:0]      k_q, k_d;
   logic [I_BITS-1:0]      i_q, i_d;
   logic [J_BITS-1:0]      j_q, j_d;
   logic [K_BITS-1:0]      kr_q, kr_d;
   logic [K_BITS-1:0]      kc_q, kc_d;
   logic [X_ADDR_BITS-1:0] x_addr_q, x_addr_d;
   logic [W_ADDR_BITS-1:0] w_addr_q, w_addr_d;
   logic                   mac_en_q, mac_en_d;
   logic                   mac_init_q, mac_init_d;
   logic                   idle_hold_q, idle_hold_d;

   logic                   k_legal;
   logic [K_BITS-1:0]      k_last_idx;
   logic [I_BITS-1:0]      i_max;
   logic [J_BITS-1:0]      j_max;
   logic                   kc_last;
   logic                   tap_last;
   logic                   i_last;
   logic                   j_last;
   logic                   pos_last;
   logic [X_ADDR_BITS-1:0] x_addr_tap;
   logic [W_ADDR_BITS-1:0] w_addr_tap;

   always_comb begin
      k_legal    = (32'(K) >= 32'd2) && (32'(K) <= 32'(MAXK)) &&
                   (32'(K) <= 32'(R)) && (32'(K) <= 32'(C));
      k_last_idx = k_q - K_BITS'(1);
      i_max      = I_BITS'(R) - I_BITS'(k_q);
      j_max      = J_BITS'(C) - J_BITS'(k_q);
      kc_last    = (kc_q == k_last_idx);
      tap_last   = kc_last && (kr_q == k_last_idx);
      i_last     = (i_q == i_max);
      j_last     = (j_q == j_max);
      pos_last   = i_last && j_last;
      // Evaluate one bit wider than the address so no partial sum wraps
      x_addr_tap = X_ADDR_BITS'((XW'(i_q) + XW'(kr_q)) * XW'(C) + XW'(j_q) + XW'(kc_q));
      w_addr_tap = W_ADDR_BITS'(WW'(kr_q) * WW'(k_q) + WW'(kc_q));
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      i_d         = i_q;
      j_d         = j_q;
      kr_d        = kr_q;
      kc_d        = kc_q;
      x_addr_d    = x_addr_q;
      w_addr_d    = w_addr_q;
      mac_en_d    = 1'b0;
      mac_init_d  = 1'b0;
      idle_hold_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // The IDLE cycle right after DONE ignores inputs_loaded
            if (inputs_loaded && !idle_hold_q) begin
               k_d     = K;
               i_d     = '0;
               j_d     = '0;
               kr_d    = '0;
               kc_d    = '0;
               state_d = k_legal ? S_ISSUE : S_DONE;
            end
         end
         S_ISSUE: begin
            mac_en_d   = 1'b1;
            mac_init_d = (kr_q == '0) && (kc_q == '0);
            x_addr_d   = x_addr_tap;
            w_addr_d   = w_addr_tap;
            if (kc_last) begin
               kc_d = '0;
               if (tap_last) begin
                  state_d = S_DRAIN;
               end else begin
                  kr_d = kr_q + K_BITS'(1);
               end
            end else begin
               kc_d = kc_q + K_BITS'(1);
            end
         end
         S_DRAIN: begin
            state_d = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (out_ready) begin
               if (pos_last) begin
                  state_d = S_DONE;
               end else begin
                  kr_d    = '0;
                  kc_d    = '0;
                  state_d = S_ISSUE;
                  if (j_last) begin
                     j_d = '0;
                     i_d = i_q + I_BITS'(1);
                  end else begin
                     j_d = j_q + J_BITS'(1);
                  end
               end
            end
         end
         S_DONE: begin
            state_d     = S_IDLE;
            idle_hold_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         i_q         <= '0;
         j_q         <= '0;
         kr_q        <= '0;
         kc_q        <= '0;
         x_addr_q    <= '0;
         w_addr_q    <= '0;
         mac_en_q    <= 1'b0;
         mac_init_q  <= 1'b0;
         idle_hold_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         i_q         <= i_d;
         j_q         <= j_d;
         kr_q        <= kr_d;
         kc_q        <= kc_d;
         x_addr_q    <= x_addr_d;
         w_addr_q    <= w_addr_d;
         mac_en_q    <= mac_en_d;
         mac_init_q  <= mac_init_d;
         idle_hold_q <= idle_hold_d;
      end
   end

   // The live tap address is driven during ISSUE; elsewhere the last issued one is held
   assign X_read_addr      = (state_q == S_ISSUE) ? x_addr_tap : x_addr_q;
   assign W_read_addr      = (state_q == S_ISSUE) ? w_addr_tap : w_addr_q;
   assign mac_en           = mac_en_q;
   assign mac_init         = mac_init_q;
   assign out_valid        = (state_q == S_OUTPUT);
   assign out_last         = (state_q == S_OUTPUT) && pos_last;
   assign compute_finished = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: scoreboard of expected taps/outputs plus a table of per-K job timings.
module tb_conv_sequencer;

   localparam int R    = 9;
   localparam int C    = 8;
   localparam int MAXK = 4;
   localparam int KB   = $clog2(MAXK + 1);
   localparam int XB   = $clog2(R * C);
   localparam int WB   = $clog2(MAXK * MAXK);

   logic          clk = 1'b0;
   logic          reset;
   logic          inputs_loaded;
   logic [KB-1:0] K;
   logic [XB-1:0] X_read_addr;
   logic [WB-1:0] W_read_addr;
   logic          mac_en;
   logic          mac_init;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          compute_finished;

   conv_sequencer #(.R(R), .C(C), .MAXK(MAXK)) dut (
      .clk             (clk),
      .reset           (reset),
      .inputs_loaded   (inputs_loaded),
      .K               (K),
      .X_read_addr     (X_read_addr),
      .W_read_addr     (W_read_addr),
      .mac_en          (mac_en),
      .mac_init        (mac_init),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_last        (out_last),
      .compute_finished(compute_finished)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int x;
      int w;
      bit init;
   } tap_t;

   typedef struct {
      int k;
      int exp_out;
      int exp_fv;
      int exp_fin;
   } vec_t;

   tap_t tapq[$];
   bit   outq[$];

   int checks = 0;
   int errors = 0;
   int n_acc, fin_cnt, fin_cyc, first_valid_cyc, stall_cyc;
   int prev_x, prev_w;
   bit prev_valid, prev_ready, prev_last;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compares every mac_en against the tap whose address was driven the cycle before
   task automatic monitor();
      tap_t t;
      bit   l;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (mac_en) begin
               if (tapq.size() == 0) begin
                  chk("unexpected_mac_en", 1, 0);
               end else begin
                  t = tapq.pop_front();
                  chk("tap_x", prev_x, t.x);
                  chk("tap_w", prev_w, t.w);
                  chk("tap_init", int'(mac_init), int'(t.init));
               end
            end
            if (out_valid) begin
               if (first_valid_cyc < 0) first_valid_cyc = cyc;
               if (prev_valid && !prev_ready) begin
                  stall_cyc++;
                  chk("stall_last", int'(out_last), int'(prev_last));
                  chk("stall_x", int'(X_read_addr), prev_x);
                  chk("stall_mac_en", int'(mac_en), 0);
               end
               if (out_ready) begin
                  if (outq.size() == 0) begin
                     chk("unexpected_output", 1, 0);
                  end else begin
                     l = outq.pop_front();
                     chk("out_last", int'(out_last), int'(l));
                  end
                  n_acc++;
               end
            end
            if (compute_finished) begin
               fin_cnt++;
               fin_cyc = cyc;
            end
         end
         prev_x     = int'(X_read_addr);
         prev_w     = int'(W_read_addr);
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_last  = out_last;
      end
   endtask

   task automatic push_job(input int k);
      if (k >= 2 && k <= MAXK && k <= R && k <= C) begin
         for (int i = 0; i <= R - k; i++) begin
            for (int j = 0; j <= C - k; j++) begin
               for (int kr = 0; kr < k; kr++) begin
                  for (int kc = 0; kc < k; kc++) begin
                     tapq.push_back('{x: (i + kr) * C + j + kc, w: kr * k + kc, init: (kr == 0 && kc == 0)});
                  end
               end
               outq.push_back(i == R - k && j == C - k);
            end
         end
      end
   endtask

   task automatic start_job(input int k, output int t0);
      K               = KB'(k);
      inputs_loaded   = 1'b1;
      n_acc           = 0;
      fin_cnt         = 0;
      fin_cyc         = -1;
      first_valid_cyc = -1;
      stall_cyc       = 0;
      push_job(k);
      t0 = cyc;
   endtask

   // Keeps inputs_loaded high one extra cycle past DONE, then idles to catch any restart
   task automatic wait_done();
      int n = 0;
      while (fin_cnt == 0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (fin_cnt == 0) chk("finish_timeout", 0, 1);
      @(posedge clk); #1;
      inputs_loaded = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("finish_pulses", fin_cnt, 1);
      chk("taps_left", tapq.size(), 0);
      chk("outputs_left", outq.size(), 0);
   endtask

   function automatic int outs_vec();
      return int'({mac_en, mac_init, out_valid, out_last, compute_finished}) + int'(X_read_addr) + int'(W_read_addr);
   endfunction

   initial begin
      vec_t vecs[6];
      int   t0;
      int   n;
      vecs[0] = '{k: 3, exp_out: 42, exp_fv: 11, exp_fin: 463};
      vecs[1] = '{k: 4, exp_out: 30, exp_fv: 18, exp_fin: 541};
      vecs[2] = '{k: 2, exp_out: 56, exp_fv: 6,  exp_fin: 337};
      vecs[3] = '{k: 1, exp_out: 0,  exp_fv: -1, exp_fin: 1};
      vecs[4] = '{k: 5, exp_out: 0,  exp_fv: -1, exp_fin: 1};
      vecs[5] = '{k: 0, exp_out: 0,  exp_fv: -1, exp_fin: 1};

      reset         = 1'b1;
      inputs_loaded = 1'b0;
      K             = '0;
      out_ready     = 1'b1;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outs_vec(), 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_outputs", outs_vec(), 0);

      foreach (vecs[v]) begin
         start_job(vecs[v].k, t0);
         wait_done();
         chk($sformatf("n_outputs_k%0d", vecs[v].k), n_acc, vecs[v].exp_out);
         chk($sformatf("first_valid_k%0d", vecs[v].k), (first_valid_cyc < 0) ? -1 : first_valid_cyc - t0, vecs[v].exp_fv);
         chk($sformatf("finish_at_k%0d", vecs[v].k), fin_cyc - t0, vecs[v].exp_fin);
      end

      // Backpressure: output 3 (i=0, j=3) waits 5 cycles for out_ready
      start_job(3, t0);
      n = 0;
      while (n_acc < 3 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_valid_seen", int'(out_valid), 1);
      chk("bp_hold_addr", int'(X_read_addr), 21);
      chk("bp_hold_last", int'(out_last), 0);
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_done();
      chk("bp_stall_cycles", stall_cyc, 5);
      chk("bp_n_outputs", n_acc, 42);
      chk("bp_finish_at", fin_cyc - t0, 468);

      // Reset in the middle of output 10's taps, then a clean restart
      start_job(3, t0);
      n = 0;
      while (n_acc < 10 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("rst_mid_issue_mac_en", int'(mac_en), 1);
      reset         = 1'b1;
      inputs_loaded = 1'b0;
      @(posedge clk); #1;
      tapq.delete();
      outq.delete();
      reset = 1'b0;
      chk("rst_outputs_zero", outs_vec(), 0);
      repeat (5) @(posedge clk);
      #1;
      chk("rst_no_finish", fin_cnt, 0);
      chk("rst_idle_outputs", outs_vec(), 0);
      start_job(3, t0);
      wait_done();
      chk("restart_n_outputs", n_acc, 42);
      chk("restart_finish_at", fin_cyc - t0, 463);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
